// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_seq_pkg: ALU select codes, sequencer states and NZCV bit positions.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

   localparam logic [4:0] SEL_AND   = 5'b00000;
   localparam logic [4:0] SEL_EOR   = 5'b00001;
   localparam logic [4:0] SEL_SUB   = 5'b00010;
   localparam logic [4:0] SEL_RSB   = 5'b00011;
   localparam logic [4:0] SEL_ADD   = 5'b00100;
   localparam logic [4:0] SEL_ADC   = 5'b00101;
   localparam logic [4:0] SEL_SBC   = 5'b00110;
   localparam logic [4:0] SEL_RSC   = 5'b00111;
   localparam logic [4:0] SEL_TST   = 5'b01000;
   localparam logic [4:0] SEL_TEQ   = 5'b01001;
   localparam logic [4:0] SEL_CMP   = 5'b01010;
   localparam logic [4:0] SEL_CMN   = 5'b01011;
   localparam logic [4:0] SEL_ORR   = 5'b01100;
   localparam logic [4:0] SEL_MOV   = 5'b01101;
   localparam logic [4:0] SEL_BIC   = 5'b01110;
   localparam logic [4:0] SEL_MVN   = 5'b01111;
   localparam logic [4:0] SEL_PASSA = 5'b10000;
   localparam logic [4:0] SEL_PASSB = 5'b10001;
   localparam logic [4:0] SEL_INC   = 5'b10010;
   localparam logic [4:0] SEL_LSR1  = 5'b10011;
   localparam logic [4:0] SEL_LSL1  = 5'b10100;
   localparam logic [4:0] SEL_MAX   = SEL_LSL1;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   function automatic logic is_shift(input logic [4:0] sel);
      return (sel == SEL_LSR1) || (sel == SEL_LSL1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_32.sv
// +----------------------------------------------------------------------------+
// | alu_32: combinational ARM-style ALU with NZCV outputs and 1-bit shifts.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_32
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       sel,
   input  logic             cin,
   output logic [WIDTH-1:0] out,
   output logic             neg,
   output logic             zero,
   output logic             carry,
   output logic             vflow
);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             add_cin;
   logic             use_adder;
   logic [WIDTH:0]   sum;

   always_comb begin
      x         = a;
      y         = b;
      add_cin   = 1'b0;
      use_adder = 1'b0;
      sum       = '0;
      out       = '0;
      carry     = cin;
      vflow     = 1'b0;
      case (sel)
         SEL_AND, SEL_TST:  out = a & b;
         SEL_EOR, SEL_TEQ:  out = a ^ b;
         SEL_ORR:           out = a | b;
         SEL_MOV, SEL_PASSB: out = b;
         SEL_BIC:           out = a & ~b;
         SEL_MVN:           out = ~b;
         SEL_PASSA:         out = a;
         SEL_SUB, SEL_CMP: begin
            y = ~b; add_cin = 1'b1; use_adder = 1'b1;
         end
         SEL_RSB: begin
            x = b; y = ~a; add_cin = 1'b1; use_adder = 1'b1;
         end
         SEL_ADD, SEL_CMN: use_adder = 1'b1;
         SEL_ADC: begin
            add_cin = cin; use_adder = 1'b1;
         end
         SEL_SBC: begin
            y = ~b; add_cin = cin; use_adder = 1'b1;
         end
         SEL_RSC: begin
            x = b; y = ~a; add_cin = cin; use_adder = 1'b1;
         end
         SEL_INC: begin
            y = '0; add_cin = 1'b1; use_adder = 1'b1;
         end
         SEL_LSR1: begin
            out = a >> 1; carry = a[0];
         end
         SEL_LSL1: begin
            out = a << 1; carry = a[WIDTH-1];
         end
         default: out = '0;
      endcase
      // Subtraction is A + ~B + carry, so C means "no borrow" as on ARM.
      if (use_adder) begin
         sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, add_cin};
         out   = sum[WIDTH-1:0];
         carry = sum[WIDTH];
         vflow = (x[WIDTH-1] == y[WIDTH-1]) && (out[WIDTH-1] != x[WIDTH-1]);
      end
   end

   assign neg  = out[WIDTH-1];
   assign zero = (out == '0);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_sequencer: multi-cycle ALU controller with N-bit shifts and NZCV reg.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_sel,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_s,
   input  logic [4:0]       req_shamt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic [3:0]       flags,
   input  logic             flags_we,
   input  logic [3:0]       flags_in
);

   seq_state_t       state;
   logic [4:0]       sel_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] b_q;
   logic             s_q;
   logic [4:0]       count;

   logic [WIDTH-1:0] alu_out;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;
   logic [3:0]       alu_flags;

   // The accumulator doubles as the latched A operand for non-shift ops.
   alu_32 #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a     (acc),
      .b     (b_q),
      .sel   (sel_q),
      .cin   (flags[FLAG_C]),
      .out   (alu_out),
      .neg   (alu_n),
      .zero  (alu_z),
      .carry (alu_c),
      .vflow (alu_v)
   );

   assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
         flags     <= 4'b0000;
         acc       <= '0;
         count     <= '0;
         sel_q     <= '0;
         b_q       <= '0;
         s_q       <= 1'b0;
      end else begin
         // Sequencer flag writes below override this external load.
         if (flags_we) flags <= flags_in;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  acc       <= req_a;
                  b_q       <= req_b;
                  s_q       <= req_s;
                  sel_q     <= req_sel;
                  count     <= req_shamt;
                  req_ready <= 1'b0;
                  if (req_sel > SEL_MAX) begin
                     res_data  <= '0;
                     res_err   <= 1'b1;
                     res_valid <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     res_err <= 1'b0;
                     if (is_shift(req_sel) && (req_shamt == 5'd0)) begin
                        sel_q <= SEL_PASSA;
                        state <= ST_EXEC;
                     end else if (is_shift(req_sel)) begin
                        state <= ST_SHIFT;
                     end else begin
                        state <= ST_EXEC;
                     end
                  end
               end
            end
            ST_EXEC: begin
               res_data  <= alu_out;
               if (s_q) flags <= alu_flags;
               res_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_SHIFT: begin
               acc   <= alu_out;
               count <= count - 5'd1;
               if (count == 5'd1) begin
                  res_data  <= alu_out;
                  if (s_q) flags <= alu_flags;
                  res_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_alu_sequencer: scoreboard bench for alu_sequencer.                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_sequencer;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic [4:0]       req_sel;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_s;
   logic [4:0]       req_shamt;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic [3:0]       flags;
   logic             flags_we;
   logic [3:0]       flags_in;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [3:0]  flg;
      int          lat;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] model_flags;
   int         checks   = 0;
   int         failures = 0;

   alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel   (req_sel),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_s     (req_s),
      .req_shamt (req_shamt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .flags     (flags),
      .flags_we  (flags_we),
      .flags_in  (flags_in)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Returns {C, V, result}; sub computes x - y - !cin, otherwise x + y + cin.
   function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                           input logic cin, input logic sub);
      longint ux, uy, sx, sy, ur, sr;
      logic   c, v;
      logic [31:0] r;
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (sub) begin
         ur = ux - uy - (cin ? 64'sd0 : 64'sd1);
         sr = sx - sy - (cin ? 64'sd0 : 64'sd1);
         c  = (ur >= 0);
      end else begin
         ur = ux + uy + (cin ? 64'sd1 : 64'sd0);
         sr = sx + sy + (cin ? 64'sd1 : 64'sd0);
         c  = (ur >= 64'sd4294967296);
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r = ur[31:0];
      return {c, v, r};
   endfunction

   // Returns {NZCV, result} for a legal select code.
   function automatic logic [35:0] ref_op(input logic [4:0] sel, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin,
                                         input logic [4:0] shamt);
      logic [33:0] r;
      logic [31:0] o;
      logic        c, v;
      int          k;
      c = cin;
      v = 1'b0;
      o = 32'd0;
      r = 34'd0;
      k = int'(shamt);
      case (int'(sel))
         0, 8:   o = a & b;
         1, 9:   o = a ^ b;
         2, 10:  r = ref_add(a, b, 1'b1, 1'b1);
         3:      r = ref_add(b, a, 1'b1, 1'b1);
         4, 11:  r = ref_add(a, b, 1'b0, 1'b0);
         5:      r = ref_add(a, b, cin, 1'b0);
         6:      r = ref_add(a, b, cin, 1'b1);
         7:      r = ref_add(b, a, cin, 1'b1);
         12:     o = a | b;
         13, 17: o = b;
         14:     o = a & ~b;
         15:     o = ~b;
         16:     o = a;
         18:     r = ref_add(a, 32'd1, 1'b0, 1'b0);
         19: begin
            o = a >> k;
            if (k != 0) c = a[k-1];
         end
         20: begin
            o = a << k;
            if (k != 0) c = a[32-k];
         end
         default: o = 32'd0;
      endcase
      if (sel inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd18}) begin
         o = r[31:0];
         c = r[33];
         v = r[32];
      end
      return {o[31], (o == 32'd0), c, v, o};
   endfunction

   task automatic push_exp(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [4:0] shamt,
                           input logic fw, input logic [3:0] fw_val);
      exp_t        e;
      logic [35:0] r;
      if (sel > 5'd20) begin
         e.data = 32'd0;
         e.err  = 1'b1;
         e.lat  = 0;
      end else begin
         r      = ref_op(sel, a, b, model_flags[1], shamt);
         e.data = r[31:0];
         e.err  = 1'b0;
         e.lat  = ((sel == 5'd19 || sel == 5'd20) && shamt != 5'd0) ? int'(shamt) : 1;
         if (fw) model_flags = fw_val;
         if (s)  model_flags = r[35:32];
      end
      e.flg = model_flags;
      sb.push_back(e);
   endtask

   task automatic send(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [4:0] shamt,
                       input logic fw, input logic [3:0] fw_val);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check_eq("req_ready_timeout", {63'd0, req_ready}, 64'd1);
      req_sel   = sel;
      req_a     = a;
      req_b     = b;
      req_s     = s;
      req_shamt = shamt;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (fw) begin
         flags_we = 1'b1;
         flags_in = fw_val;
      end
      push_exp(sel, a, b, s, shamt, fw, fw_val);
   endtask

   task automatic collect(input logic hs);
      int   n = 0;
      exp_t e;
      while (!res_valid && n < 40) begin
         @(posedge clk); #1;
         flags_we = 1'b0;
         n++;
      end
      check_eq("res_valid", {63'd0, res_valid}, 64'd1);
      if (sb.size() == 0) begin
         check_eq("scoreboard_empty", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check_eq("latency", 64'(n), 64'(e.lat));
         check_eq("res_data", {32'd0, res_data}, {32'd0, e.data});
         check_eq("res_err", {63'd0, res_err}, {63'd0, e.err});
         check_eq("flags", {60'd0, flags}, {60'd0, e.flg});
      end
      if (hs) begin
         res_ready = 1'b1;
         @(posedge clk); #1;
         flags_we  = 1'b0;
         res_ready = 1'b0;
         check_eq("idle_after_hs", {62'd0, res_valid, req_ready}, 64'd1);
      end
   endtask

   task automatic load_flags(input logic [3:0] v);
      flags_we = 1'b1;
      flags_in = v;
      @(posedge clk); #1;
      flags_we    = 1'b0;
      model_flags = v;
      check_eq("flags_load", {60'd0, flags}, {60'd0, v});
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_sel     = '0;
      req_a       = '0;
      req_b       = '0;
      req_s       = 1'b0;
      req_shamt   = '0;
      res_ready   = 1'b0;
      flags_we    = 1'b0;
      flags_in    = '0;
      model_flags = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
      check_eq("rst_res_data", {32'd0, res_data}, 64'd0);
      check_eq("rst_res_err", {63'd0, res_err}, 64'd0);
      check_eq("rst_flags", {60'd0, flags}, 64'd0);

      // ADD with S, then ADC consuming the stored carry.
      send(5'b00100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd0, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b00101, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 4'd0);
      collect(1'b1);

      // Multi-bit shifts, zero-length shift, and a subtract with flags.
      send(5'b10100, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 5'd4, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b10100, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b10011, 32'h0000_000F, 32'h0, 1'b1, 5'd3, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b10100, 32'h8000_0001, 32'h0, 1'b1, 5'd1, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b00010, 32'd5, 32'd7, 1'b1, 5'd0, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b00100, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd0, 1'b0, 4'd0);
      collect(1'b1);

      for (int i = 0; i < 10; i++) begin
         send(5'($urandom_range(0, 20)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'b0, 4'd0);
         collect(1'b1);
      end

      // Backpressure with a second request waiting on req_valid.
      req_sel = 5'b00100; req_a = 32'd3; req_b = 32'd4; req_s = 1'b0; req_shamt = 5'd0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      push_exp(5'b00100, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 4'd0);
      req_a = 32'd10; req_b = 32'd20;
      collect(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("bp_data", {32'd0, res_data}, 64'd7);
         check_eq("bp_ready_valid", {62'd0, req_ready, res_valid}, 64'd1);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_eq("bp_hs_idle", {62'd0, res_valid, req_ready}, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("bp_second_accepted", {63'd0, req_ready}, 64'd0);
      push_exp(5'b00100, 32'd10, 32'd20, 1'b0, 5'd0, 1'b0, 4'd0);
      collect(1'b1);

      // Illegal select leaves flags alone; ALU flags beat a concurrent flags_we.
      load_flags(4'b1001);
      send(5'b11000, 32'h1234_5678, 32'h1, 1'b1, 5'd0, 1'b0, 4'd0);
      collect(1'b1);
      send(5'b00100, 32'd1, 32'd1, 1'b1, 5'd0, 1'b1, 4'b1111);
      collect(1'b1);
      send(5'b00000, 32'hF0, 32'h3C, 1'b0, 5'd0, 1'b1, 4'b1010);
      collect(1'b1);

      // Reset in the middle of a long shift.
      load_flags(4'b0110);
      send(5'b10100, 32'h1, 32'h0, 1'b1, 5'd20, 1'b0, 4'd0);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_eq("rst_mid_valid", {63'd0, res_valid}, 64'd0);
      check_eq("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      check_eq("rst_mid_flags", {60'd0, flags}, 64'd0);
      sb.delete();
      model_flags = 4'b0000;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("post_rst_idle", {62'd0, res_valid, req_ready}, 64'd1);
      send(5'b00010, 32'd9, 32'd9, 1'b1, 5'd0, 1'b0, 4'd0);
      collect(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
